// File: rtl/conv3d_layer_ctrl.sv
// conv3d_layer_ctrl
// -----------------
// Layer-level sequencer for the conv3d engine. For each (output channel, input
// channel) pair of one convolution layer it prefetches that pass's weights and
// then issues one conv3d pass. It sets the input, partial-sum and output plane
// addresses for the pass. Input channels are the inner loop. Pass ic=0 reads
// the bias plane as y. Later passes read back the output plane being built.
//
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   start, abort          launch pulse (ignored while busy), synchronous abort
//   d_*                   layer descriptor, captured when start is accepted
//   cfg_prefetch/waddr    weight prefetch pulse and weight block address
//   cfg_ena/x/y/zbase     pass start pulse and plane addresses
//   w_done, pass_done     completion pulses from the engine
//   busy, layer_done      layer in progress / one-cycle completion pulse
//   cur_ic, cur_oc        channel pair of the current (or last) pass
module conv3d_layer_ctrl #(
    parameter int unsigned AW = 30,
    parameter int unsigned CW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [AW-1:0] d_in_base,
    input  logic [AW-1:0] d_in_stride,
    input  logic [AW-1:0] d_out_base,
    input  logic [AW-1:0] d_out_stride,
    input  logic [AW-1:0] d_bias_base,
    input  logic [AW-1:0] d_w_base,
    input  logic [AW-1:0] d_w_stride,
    input  logic [CW-1:0] d_num_in,
    input  logic [CW-1:0] d_num_out,
    output logic          cfg_prefetch,
    output logic [AW-1:0] cfg_waddr,
    output logic          cfg_ena,
    output logic [AW-1:0] cfg_xbase,
    output logic [AW-1:0] cfg_ybase,
    output logic [AW-1:0] cfg_zbase,
    input  logic          w_done,
    input  logic          pass_done,
    output logic          busy,
    output logic          layer_done,
    output logic [CW-1:0] cur_ic,
    output logic [CW-1:0] cur_oc
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WLOAD = 3'd1;
    localparam logic [2:0] S_WWAIT = 3'd2;
    localparam logic [2:0] S_PASS  = 3'd3;
    localparam logic [2:0] S_PWAIT = 3'd4;
    localparam logic [2:0] S_NEXT  = 3'd5;
    localparam logic [2:0] S_FIN   = 3'd6;

    logic [2:0]    state;
    logic [2:0]    state_nx;

    // Descriptor copies captured when start is accepted
    logic [AW-1:0] in_base_r;
    logic [AW-1:0] in_stride_r;
    logic [AW-1:0] out_stride_r;
    logic [AW-1:0] bias_r;
    logic [AW-1:0] w_stride_r;
    logic [CW-1:0] num_in_r;
    logic [CW-1:0] num_out_r;

    logic          accept;
    logic          zero_chan;
    logic          last_ic;
    logic          last_oc;
    logic          advance;

    always_comb begin
        accept    = (state == S_IDLE) && start && !abort;
        zero_chan = (d_num_in == '0) || (d_num_out == '0);
        // Exact equality with count-1 so that the full 2^CW-1 count is legal
        last_ic   = (cur_ic == num_in_r - CW'(1));
        last_oc   = (cur_oc == num_out_r - CW'(1));
        // The final NEXT does not advance, so the counters and addresses
        // keep the values of the last pass after FIN
        advance   = (state == S_NEXT) && !abort && !(last_ic && last_oc);
    end

    // Pulses are decoded from the state and masked by abort so that an
    // aborted cycle never emits prefetch, ena or layer_done
    always_comb begin
        cfg_prefetch = (state == S_WLOAD) && !abort;
        cfg_ena      = (state == S_PASS) && !abort;
        layer_done   = (state == S_FIN) && !abort;
        busy         = (state != S_IDLE);
    end

    always_comb begin
        state_nx = state;
        if (abort) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start) state_nx = zero_chan ? S_FIN : S_WLOAD;
                S_WLOAD: state_nx = S_WWAIT;
                S_WWAIT: if (w_done) state_nx = S_PASS;
                S_PASS:  state_nx = S_PWAIT;
                S_PWAIT: if (pass_done) state_nx = S_NEXT;
                S_NEXT:  state_nx = (last_ic && last_oc) ? S_FIN : S_WLOAD;
                S_FIN:   state_nx = S_IDLE;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            in_base_r    <= '0;
            in_stride_r  <= '0;
            out_stride_r <= '0;
            bias_r       <= '0;
            w_stride_r   <= '0;
            num_in_r     <= '0;
            num_out_r    <= '0;
            cfg_waddr    <= '0;
            cfg_xbase    <= '0;
            cfg_ybase    <= '0;
            cfg_zbase    <= '0;
            cur_ic       <= '0;
            cur_oc       <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                in_base_r    <= d_in_base;
                in_stride_r  <= d_in_stride;
                out_stride_r <= d_out_stride;
                bias_r       <= d_bias_base;
                w_stride_r   <= d_w_stride;
                num_in_r     <= d_num_in;
                num_out_r    <= d_num_out;
                cfg_waddr    <= d_w_base;
                cfg_xbase    <= d_in_base;
                cfg_ybase    <= d_bias_base;
                cfg_zbase    <= d_out_base;
                cur_ic       <= '0;
                cur_oc       <= '0;
            end else if (advance) begin
                // Weights are stored oc-major, ic-minor: one running sum
                cfg_waddr <= cfg_waddr + w_stride_r;
                if (last_ic) begin
                    cur_ic    <= '0;
                    cur_oc    <= cur_oc + CW'(1);
                    cfg_xbase <= in_base_r;
                    cfg_zbase <= cfg_zbase + out_stride_r;
                    cfg_ybase <= bias_r;
                end else begin
                    cur_ic    <= cur_ic + CW'(1);
                    cfg_xbase <= cfg_xbase + in_stride_r;
                    // Accumulate onto the output plane currently being built
                    cfg_ybase <= cfg_zbase;
                end
            end
        end
    end

endmodule
